writeback_arbiter: RTL and testbench

- Sits downstream of every functional unit (FU); it is the consumer side of the FU result interface.
- Each FU presents a result (inst_id, per-operand PRN/data/data_valid). The block buffers results per FU and picks one FU per cycle with round-robin arbitration.
- The winner drives the PRF write ports, the set_prn/set_prn_ready wakeup broadcast to all issue queues, and the ROB completion port.
- A per-FU ready signal gives FUs backpressure so no result is ever dropped.

---
 rtl/wb_pkg.sv | 30 +++
 rtl/writeback_arbiter_if.sv | 37 +++
 rtl/wb_fifo.sv | 63 ++++++
 rtl/writeback_arbiter.sv | 151 +++++++++++++++
 tb/tb_writeback_arbiter.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter slice.
package wb_pkg;

  localparam int unsigned INST_ID_BITS = 6;
  localparam int unsigned PRN_BITS     = 6;
  localparam int unsigned MAX_OPERANDS = 3;
  localparam int unsigned FU_COUNT     = 4;
  localparam int unsigned BUF_DEPTH    = 2;
  localparam int unsigned DATA_BITS    = 64;
  localparam int unsigned FU_IDX_BITS  = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1;
  localparam int unsigned CNT_BITS     = $clog2(BUF_DEPTH + 1);
  localparam int unsigned PTR_BITS     = $clog2(BUF_DEPTH);

  typedef logic [FU_IDX_BITS-1:0] fu_idx_t;

  // One buffered FU result
  typedef struct packed {
    logic [INST_ID_BITS-1:0]                    inst_id;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]      prn;
    logic [MAX_OPERANDS-1:0][DATA_BITS-1:0]     data;
    logic [MAX_OPERANDS-1:0]                    data_valid;
  } wb_entry_t;

  // Round-robin successor of a grant index
  function automatic fu_idx_t rr_next(input fu_idx_t grant);
    if (grant == FU_IDX_BITS'(FU_COUNT - 1)) return '0;
    return grant + FU_IDX_BITS'(1);
  endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// FU result bus plus PRF/wakeup/ROB writeback bus of the writeback arbiter.
interface writeback_arbiter_if;
  import wb_pkg::*;

  logic [FU_COUNT-1:0]                                 fu_out_valid;
  logic [FU_COUNT-1:0]                                 fu_in_ready;
  logic [FU_COUNT-1:0][INST_ID_BITS-1:0]               fu_out_inst_id;
  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] fu_out_prn;
  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][DATA_BITS-1:0] fu_out_data;
  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]               fu_out_data_valid;

  logic [MAX_OPERANDS-1:0]                 prf_write_en;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]   prf_write_prn;
  logic [MAX_OPERANDS-1:0][DATA_BITS-1:0]  prf_write_data;
  logic [MAX_OPERANDS-1:0]                 set_prn_ready;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]   set_prn;
  logic                                    rob_complete_valid;
  logic [INST_ID_BITS-1:0]                 rob_complete_inst_id;
  logic [31:0]                             wb_stat_completions;
  logic [31:0]                             wb_stat_stall_cycles;

  // Functional-unit / environment side
  modport master (
    output fu_out_valid, fu_out_inst_id, fu_out_prn, fu_out_data, fu_out_data_valid,
    input  fu_in_ready, prf_write_en, prf_write_prn, prf_write_data, set_prn_ready,
    input  set_prn, rob_complete_valid, rob_complete_inst_id,
    input  wb_stat_completions, wb_stat_stall_cycles
  );

  // Writeback arbiter side
  modport slave (
    input  fu_out_valid, fu_out_inst_id, fu_out_prn, fu_out_data, fu_out_data_valid,
    output fu_in_ready, prf_write_en, prf_write_prn, prf_write_data, set_prn_ready,
    output set_prn, rob_complete_valid, rob_complete_inst_id,
    output wb_stat_completions, wb_stat_stall_cycles
  );
endinterface

// File: rtl/wb_fifo.sv
// Per-FU result FIFO: BUF_DEPTH entries, synchronous clear, no pass-through.
module wb_fifo
  import wb_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clear_i,
  input  logic                push_i,
  input  wb_entry_t           din_i,
  input  logic                pop_i,
  output wb_entry_t           dout_o,
  output logic [CNT_BITS-1:0] count_o,
  output logic                full_o,
  output logic                empty_o
);

  wb_entry_t           mem_q [BUF_DEPTH];
  logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic                do_push, do_pop;

  assign full_o  = (count_q == CNT_BITS'(BUF_DEPTH));
  assign empty_o = (count_q == '0);
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Next pointer/count; a full FIFO refuses a push even while popping
  always_comb begin
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_BITS'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
      count_d = count_q + CNT_BITS'(do_push) - CNT_BITS'(do_pop);
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage, data only, needs no reset
  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: buffers FU results, round-robin picks one per cycle and
// drives PRF writes, wakeup broadcast and ROB completion.
// Optional WB_STATS_EN macro adds completion and stall counters.
module writeback_arbiter
  import wb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  writeback_arbiter_if.slave bus
);

  wb_entry_t           fifo_din  [FU_COUNT];
  wb_entry_t           fifo_head [FU_COUNT];
  logic [CNT_BITS-1:0] fifo_count[FU_COUNT];
  logic [FU_COUNT-1:0] fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FU_COUNT-1:0] ready_q, ready_d;
  fu_idx_t             rr_ptr_q, rr_ptr_d, grant_idx, cand;
  logic                grant_valid;
  wb_entry_t           head_sel;
  int                  nxt;

  logic                                   rob_valid_q, rob_valid_d;
  logic [INST_ID_BITS-1:0]                rob_id_q, rob_id_d;
  logic [MAX_OPERANDS-1:0]                wr_en_q, wr_en_d;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  prn_q, prn_d;
  logic [MAX_OPERANDS-1:0][DATA_BITS-1:0] data_q, data_d;

  for (genvar g = 0; g < int'(FU_COUNT); g++) begin : g_fu
    assign fifo_din[g] = '{inst_id:    bus.fu_out_inst_id[g],
                           prn:        bus.fu_out_prn[g],
                           data:       bus.fu_out_data[g],
                           data_valid: bus.fu_out_data_valid[g]};
    assign fifo_push[g] = bus.fu_out_valid[g] && ready_q[g] && !fifo_full[g];
    assign fifo_pop[g]  = grant_valid && !flush && (grant_idx == fu_idx_t'(g));

    wb_fifo u_fifo (
      .clk     (clk),
      .rst     (rst),
      .clear_i (flush),
      .push_i  (fifo_push[g]),
      .din_i   (fifo_din[g]),
      .pop_i   (fifo_pop[g]),
      .dout_o  (fifo_head[g]),
      .count_o (fifo_count[g]),
      .full_o  (fifo_full[g]),
      .empty_o (fifo_empty[g])
    );
  end

  // Ready for next cycle from next occupancy, so it is a pure register output
  always_comb begin
    nxt     = 0;
    ready_d = '0;
    for (int i = 0; i < int'(FU_COUNT); i++) begin
      nxt = int'(fifo_count[i]) + int'(fifo_push[i]) - int'(fifo_pop[i]);
      ready_d[i] = flush || (nxt < int'(BUF_DEPTH));
    end
  end

  // Round-robin search from rr_ptr over non-empty FIFOs
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = rr_ptr_q;
    cand        = '0;
    for (int k = 0; k < int'(FU_COUNT); k++) begin
      cand = fu_idx_t'((int'(rr_ptr_q) + k) % int'(FU_COUNT));
      if (!grant_valid && !fifo_empty[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
    rr_ptr_d = (grant_valid && !flush) ? rr_next(grant_idx) : rr_ptr_q;
  end

  assign head_sel = fifo_head[grant_idx];

  // Writeback next-state: strobes only on a grant, payload holds otherwise
  always_comb begin
    rob_valid_d = 1'b0;
    rob_id_d    = rob_id_q;
    wr_en_d     = '0;
    prn_d       = prn_q;
    data_d      = data_q;
    if (grant_valid && !flush) begin
      rob_valid_d = 1'b1;
      rob_id_d    = head_sel.inst_id;
      wr_en_d     = head_sel.data_valid;
      prn_d       = head_sel.prn;
      data_d      = head_sel.data;
    end
  end

  // Arbiter pointer, ready and writeback output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q    <= '0;
      ready_q     <= '0;
      rob_valid_q <= 1'b0;
      rob_id_q    <= '0;
      wr_en_q     <= '0;
      prn_q       <= '0;
      data_q      <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      ready_q     <= ready_d;
      rob_valid_q <= rob_valid_d;
      rob_id_q    <= rob_id_d;
      wr_en_q     <= wr_en_d;
      prn_q       <= prn_d;
      data_q      <= data_d;
    end
  end

  assign bus.fu_in_ready          = ready_q;
  assign bus.rob_complete_valid   = rob_valid_q;
  assign bus.rob_complete_inst_id = rob_id_q;
  assign bus.prf_write_en         = wr_en_q;
  assign bus.set_prn_ready        = wr_en_q;
  assign bus.prf_write_prn        = prn_q;
  assign bus.set_prn              = prn_q;
  assign bus.prf_write_data       = data_q;

`ifdef WB_STATS_EN
  logic [31:0] stat_comp_q, stat_comp_d, stat_stall_q, stat_stall_d;

  // Completion and backpressure counters, wrap naturally, survive flush
  always_comb begin
    stat_comp_d  = stat_comp_q + 32'(rob_valid_q);
    stat_stall_d = stat_stall_q + 32'(|(bus.fu_out_valid & ~ready_q));
  end

  // Statistics registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_comp_q  <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_comp_q  <= stat_comp_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign bus.wb_stat_completions  = stat_comp_q;
  assign bus.wb_stat_stall_cycles = stat_stall_q;
`else
  assign bus.wb_stat_completions  = '0;
  assign bus.wb_stat_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: vector table plus backpressure,
// flush and asynchronous reset sequences.
module tb_writeback_arbiter;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  writeback_arbiter_if bus();

  writeback_arbiter dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] v;
    logic [5:0] base;
    logic [2:0] dv;
    logic       rv;
    logic [5:0] id;
    logic [2:0] en;
    logic [3:0] rdy;
  } vec_t;

  vec_t       tbl [14];
  int         n_vec = 0;
  int         n_err = 0;
  logic       ovf_seen = 1'b0;
  int         seq [4];
  int         exp_seq [4];
  logic       seen_low1;
  logic [1:0] cf;
  logic       v;

  // Occupancy watch on every FIFO
  always @(negedge clk) begin
    if (dut.g_fu[0].u_fifo.count_o > CNT_BITS'(BUF_DEPTH) ||
        dut.g_fu[1].u_fifo.count_o > CNT_BITS'(BUF_DEPTH) ||
        dut.g_fu[2].u_fifo.count_o > CNT_BITS'(BUF_DEPTH) ||
        dut.g_fu[3].u_fifo.count_o > CNT_BITS'(BUF_DEPTH))
      ovf_seen <= 1'b1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_fu(input int f, input logic vld, input logic [5:0] id, input logic [2:0] dv);
    bus.fu_out_valid[f]   = vld;
    bus.fu_out_inst_id[f] = id;
    for (int j = 0; j < 3; j++) begin
      bus.fu_out_prn[f][j]        = id + 6'(2 + j);
      bus.fu_out_data[f][j]       = 64'hDEA8 + 64'(id) + 64'(j) * 64'h100;
      bus.fu_out_data_valid[f][j] = dv[j];
    end
  endtask

  task automatic idle_all();
    for (int f = 0; f < 4; f++) drive_fu(f, 1'b0, 6'd0, 3'b000);
  endtask

  // Checks the writeback outputs; payload only when a completion is expected
  task automatic chk_out(input string tag, input logic rv, input logic [5:0] id, input logic [2:0] en);
    chk({tag, "_rv"}, bus.rob_complete_valid, rv);
    chk({tag, "_en"}, bus.prf_write_en, en);
    chk({tag, "_setrdy"}, bus.set_prn_ready, en);
    if (rv) begin
      chk({tag, "_id"}, bus.rob_complete_inst_id, id);
      chk({tag, "_prn0"}, bus.prf_write_prn[0], id + 6'd2);
      chk({tag, "_setprn0"}, bus.set_prn[0], id + 6'd2);
      chk({tag, "_prn2"}, bus.prf_write_prn[2], id + 6'd4);
      chk({tag, "_data0"}, bus.prf_write_data[0], 64'hDEA8 + 64'(id));
    end
  endtask

  initial begin
    tbl[0]  = '{4'b0100, 6'd3,  3'b001, 1'b0, 6'd0,  3'b000, 4'b1111};
    tbl[1]  = '{4'b0000, 6'd0,  3'b000, 1'b1, 6'd5,  3'b001, 4'b1111};
    tbl[2]  = '{4'b1111, 6'd10, 3'b111, 1'b0, 6'd0,  3'b000, 4'b1111};
    tbl[3]  = '{4'b1111, 6'd20, 3'b111, 1'b1, 6'd13, 3'b111, 4'b1000};
    tbl[4]  = '{4'b1111, 6'd30, 3'b111, 1'b1, 6'd10, 3'b111, 4'b0001};
    tbl[5]  = '{4'b0000, 6'd0,  3'b000, 1'b1, 6'd11, 3'b111, 4'b0011};
    tbl[6]  = '{4'b0000, 6'd0,  3'b000, 1'b1, 6'd12, 3'b111, 4'b0111};
    tbl[7]  = '{4'b0000, 6'd0,  3'b000, 1'b1, 6'd23, 3'b111, 4'b1111};
    tbl[8]  = '{4'b0001, 6'd40, 3'b000, 1'b1, 6'd20, 3'b111, 4'b1111};
    tbl[9]  = '{4'b0000, 6'd0,  3'b000, 1'b1, 6'd21, 3'b111, 4'b1111};
    tbl[10] = '{4'b0000, 6'd0,  3'b000, 1'b1, 6'd22, 3'b111, 4'b1111};
    tbl[11] = '{4'b0000, 6'd0,  3'b000, 1'b1, 6'd33, 3'b111, 4'b1111};
    tbl[12] = '{4'b0000, 6'd0,  3'b000, 1'b1, 6'd40, 3'b000, 4'b1111};
    tbl[13] = '{4'b0000, 6'd0,  3'b000, 1'b0, 6'd0,  3'b000, 4'b1111};

    // Reset state
    rst   = 1'b1;
    flush = 1'b0;
    idle_all();
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_out("rst", 1'b0, 6'd0, 3'b000);
    chk("rst_rdy", bus.fu_in_ready, 4'b0000);
    chk("rst_prn0", bus.prf_write_prn[0], 6'd0);
    @(negedge clk);
    rst = 1'b1;
    chk("rel_rdy_pre", bus.fu_in_ready, 4'b0000);
    @(negedge clk);
    chk("rel_rdy_post", bus.fu_in_ready, 4'b1111);

    // Vector table
    for (int r = 0; r < 14; r++) begin
      for (int f = 0; f < 4; f++)
        drive_fu(f, tbl[r].v[f], tbl[r].base + 6'(f), tbl[r].dv);
      @(negedge clk);
      chk_out($sformatf("t%0d", r), tbl[r].rv, tbl[r].id, tbl[r].en);
      chk($sformatf("t%0d_rdy", r), bus.fu_in_ready, tbl[r].rdy);
    end
`ifdef WB_STATS_EN
    chk("stat_comp", bus.wb_stat_completions, 32'd11);
    chk("stat_stall", bus.wb_stat_stall_cycles, 32'd1);
`endif

    // Backpressure: FU1 sends three results while FU0/2/3 stream
    seen_low1 = 1'b0;
    for (int f = 0; f < 4; f++) begin
      seq[f]     = 0;
      exp_seq[f] = 0;
    end
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (bus.rob_complete_valid) begin
        cf = bus.rob_complete_inst_id[5:4];
        chk("bp_order", bus.rob_complete_inst_id, {cf, 4'(exp_seq[cf])});
        chk("bp_known", 64'(exp_seq[cf] < seq[cf]), 64'd1);
        exp_seq[cf]++;
      end
      for (int f = 0; f < 4; f++) begin
        v = (f == 1) ? (cyc >= 1 && seq[1] < 3) : (cyc < 12);
        drive_fu(f, v, {2'(f), 4'(seq[f])}, 3'b111);
      end
      for (int f = 0; f < 4; f++) begin
        if (bus.fu_out_valid[f] && bus.fu_in_ready[f]) seq[f]++;
      end
      if (bus.fu_out_valid[1] && !bus.fu_in_ready[1]) seen_low1 = 1'b1;
      @(negedge clk);
    end
    for (int f = 0; f < 4; f++)
      chk($sformatf("bp_drain%0d", f), 64'(exp_seq[f]), 64'(seq[f]));
    chk("bp_fu1_cnt", 64'(seq[1]), 64'd3);
    chk("bp_fu1_blocked", seen_low1, 1'b1);
    chk_out("bp_idle", 1'b0, 6'd0, 3'b000);

    // Flush with entries in FU0 and FU3
    idle_all();
    drive_fu(0, 1'b1, 6'h0A, 3'b111);
    drive_fu(3, 1'b1, 6'h3A, 3'b111);
    @(negedge clk);
    drive_fu(3, 1'b0, 6'h00, 3'b000);
    drive_fu(0, 1'b1, 6'h0B, 3'b111);
    @(negedge clk);
    chk("fl_pre_rv", bus.rob_complete_valid, 1'b1);
    flush = 1'b1;
    drive_fu(0, 1'b1, 6'h0C, 3'b111);
    drive_fu(1, 1'b1, 6'h1A, 3'b111);
    @(negedge clk);
    flush = 1'b0;
    idle_all();
    chk_out("fl", 1'b0, 6'd0, 3'b000);
    chk("fl_rdy", bus.fu_in_ready, 4'b1111);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("fl_stale%0d", c), bus.rob_complete_valid, 1'b0);
    end

    // Asynchronous reset in the middle of traffic
    for (int f = 0; f < 4; f++) drive_fu(f, 1'b1, {2'(f), 4'h5}, 3'b011);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk_out("ar", 1'b0, 6'd0, 3'b000);
    chk("ar_rdy", bus.fu_in_ready, 4'b0000);
    chk("ar_id", bus.rob_complete_inst_id, 6'd0);
    chk("ar_data0", bus.prf_write_data[0], 64'd0);
`ifdef WB_STATS_EN
    chk("ar_stat_comp", bus.wb_stat_completions, 32'd0);
    chk("ar_stat_stall", bus.wb_stat_stall_cycles, 32'd0);
`endif
    for (int f = 0; f < 4; f++) drive_fu(f, 1'b1, {2'(f), 4'h0}, 3'b001);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("ar_rdy_up", bus.fu_in_ready, 4'b1111);
    chk("ar_e0_rv", bus.rob_complete_valid, 1'b0);
    @(negedge clk);
    chk("ar_e1_rv", bus.rob_complete_valid, 1'b0);
    for (int f = 0; f < 4; f++) begin
      @(negedge clk);
      chk_out($sformatf("ar_g%0d", f), 1'b1, {2'(f), 4'h0}, 3'b001);
    end

    chk("no_overflow", ovf_seen, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
